seq_sort_stream: RTL and testbench
==================================

// Module: seq_sort_stream
// PURPOSE
//  Parametrised streaming insertion sorter, successor to the fixed 12-entry sequential sorter.
//  Accepts a frame of {key,index} words one per cycle over a valid/ready handshake and keeps
//  them sorted on insertion. After the frame ends it drains the words in sorted order over a
//  second valid/ready handshake. Sits between the sample source and the ranking/readout logic.
// PARAMETERS
//  KEY_W    8   key width; the sort field is DataIn[KEY_W+IDX_W-1:IDX_W]
//  IDX_W    4   tag width; DataIn[IDX_W-1:0] is carried unchanged with its key
//  DEPTH    12  maximum words per frame, >=2
//  DESCEND  0   0: ascending output (smallest key first); 1: descending
//  (local) CNT_W = $clog2(DEPTH+1)
// PORTS
//  Clk       in   1              rising-edge clock
//  Reset     in   1              asynchronous, active-high reset
//  InValid   in   1              DataIn/InLast valid
//  InReady   out  1              sorter accepts input (FILL state)
//  DataIn    in   KEY_W+IDX_W    {key, index}
//  InLast    in   1              qualifies the accepted word as the last of its frame
//  OutValid  out  1              DataOut valid (DRAIN state)
//  OutReady  in   1              consumer takes DataOut
//  DataOut   out  KEY_W+IDX_W    current sorted head {key, index}
//  OutLast   out  1              DataOut is the final word of the frame
//  Count     out  CNT_W          number of words held
// BEHAVIOUR
//  - Storage: DEPTH slots slot[0..DEPTH-1] plus Count. slot[0] is always the output head.
//  - States: FILL (reset state) and DRAIN. InReady = (state==FILL). OutValid = (state==DRAIN).
//  - Reset (async, any state): state=FILL, Count=0, all slots=0. Outputs: InReady=1, OutValid=0,
//    DataOut=0, OutLast=0, Count=0. A reset mid-frame or mid-drain discards the frame.
//  - FILL, accept = InValid&InReady: one cycle per word. The word is compared in parallel against
//    all occupied slots and inserted at position p = number of occupied slots that sort
//    before-or-equal to it. Slots p..Count-1 shift up one position. Count increments.
//  - Ties (equal keys): the new word goes after existing equal keys, so the sort is stable and
//    arrival order is kept. This holds in both ascending and descending mode.
//  - Key compare is unsigned over KEY_W bits. The index is never compared.
//  - FILL->DRAIN on the edge that accepts a word with InLast=1, or that makes Count==DEPTH.
//    A DEPTH-th word without InLast therefore forces a drain.
//  - Latency: OutValid rises the cycle after the last accepting edge. DataOut=slot[0] is
//    registered, with no combinational path from DataIn.
//  - DRAIN: OutLast = (Count==1). On OutValid&OutReady, all slots shift down by one and Count
//    decrements. With OutReady=0, DataOut/OutLast/Count hold.
//  - DRAIN->FILL on the handshake where OutLast=1. Count becomes 0 and InReady is 1 on the
//    next cycle. Vacated slots are zeroed as they shift.
//  - InValid in DRAIN is ignored (InReady=0). No input is accepted in the same cycle as output.
//  - A frame holds 1..DEPTH words. InValid=0 never ends a frame; stalls of any length are legal.
// TESTING
//  1 Default params; feed one per cycle
//    {246,0}{64,1}{234,2}{82,3}{104,4}{151,5}{141,6}{229,7}{198,8}{142,9}{140,10}{123,11},
//    InLast on the last word -> Count=12, then 12 outputs in order
//    64/1,82/3,104/4,123/11,140/10,141/6,142/9,151/5,198/8,229/7,234/2,246/0; OutLast only on 246/0.
//  2 DESCEND=1 with the same stimulus -> exact reverse order, first output 246/0, OutLast on 64/1.
//  3 Ties: {50,0}{20,1}{50,2}{20,3} with InLast -> 20/1,20/3,50/0,50/2 (stable).
//  4 Backpressure: scenario 1 with OutReady toggled 1,0,0,1,... ->
//    DataOut holds while OutReady=0; same 12-word sequence; no word dropped or duplicated.
//  5 Overflow: 12 words with InLast=0 -> InReady=0 and OutValid=1 the next cycle;
//    a 13th InValid word is not accepted. Next frame {7,5} with InLast -> single output 7/5, OutLast=1.
//  6 Reset mid-drain after 3 outputs -> immediately OutValid=0, Count=0, InReady=1;
//    the next 2-word frame {9,1}{3,2} -> 3/2,9/1.

Source files
------------

// File: rtl/seq_sort_stream.sv
`default_nettype none
// ============================================================================
//  Module      : seq_sort_stream
//  Description : Streaming stable insertion sorter. Fills a frame over one
//                valid/ready port, then drains it in sorted order over another.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module seq_sort_stream #(
    parameter int KEY_W   = 8,
    parameter int IDX_W   = 4,
    parameter int DEPTH   = 12,
    parameter int DESCEND = 0,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [KEY_W+IDX_W-1:0]   DataIn,
    input  logic                     InLast,
    output logic                     OutValid,
    input  logic                     OutReady,
    output logic [KEY_W+IDX_W-1:0]   DataOut,
    output logic                     OutLast,
    output logic [CNT_W-1:0]         Count
);

    localparam int               c_dw    = KEY_W + IDX_W;
    localparam logic [CNT_W-1:0] c_last  = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);

    typedef enum logic [0:0] {
        S_FILL  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t            r_state;
    logic [c_dw-1:0]   r_slot [DEPTH];
    logic [CNT_W-1:0]  r_count;

    logic [DEPTH-1:0]  w_before;
    logic [c_dw-1:0]   w_ins   [DEPTH];
    logic [c_dw-1:0]   w_shift [DEPTH];
    logic [KEY_W-1:0]  w_key_in;

    assign w_key_in = DataIn[c_dw-1:IDX_W];

    // Occupied slots that sort before-or-equal to the new word form a prefix,
    // so the insertion point is where w_before first drops to zero.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [KEY_W-1:0] w_key_s;
            assign w_key_s = r_slot[gi][c_dw-1:IDX_W];

            always_comb begin
                w_before[gi] = 1'b0;
                if (CNT_W'(gi) < r_count) begin
                    if (DESCEND != 0)
                        w_before[gi] = (w_key_s >= w_key_in);
                    else
                        w_before[gi] = (w_key_s <= w_key_in);
                end
            end

            if (gi == 0) begin : g_head
                assign w_ins[gi] = w_before[gi] ? r_slot[gi] : DataIn;
            end else begin : g_body
                assign w_ins[gi] = w_before[gi]     ? r_slot[gi]   :
                                   w_before[gi-1]   ? DataIn       :
                                                      r_slot[gi-1];
            end

            if (gi == DEPTH - 1) begin : g_tail
                assign w_shift[gi] = '0;
            end else begin : g_mid
                assign w_shift[gi] = r_slot[gi+1];
            end
        end
    endgenerate

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_FILL;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_slot[i] <= '0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (InValid) begin
                        for (int i = 0; i < DEPTH; i++) r_slot[i] <= w_ins[i];
                        r_count <= r_count + c_one;
                        if (InLast || (r_count == c_last)) r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (OutReady) begin
                        for (int i = 0; i < DEPTH; i++) r_slot[i] <= w_shift[i];
                        r_count <= r_count - c_one;
                        if (r_count == c_one) r_state <= S_FILL;
                    end
                end
                default: r_state <= S_FILL;
            endcase
        end
    end

    assign InReady  = (r_state == S_FILL);
    assign OutValid = (r_state == S_DRAIN);
    assign DataOut  = r_slot[0];
    assign OutLast  = (r_state == S_DRAIN) && (r_count == c_one);
    assign Count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_seq_sort_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_sort_stream
//  Description : Self-checking bench; ascending and descending sorters share
//                one input stream and are compared against a selection model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_sort_stream;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        InValid;
    logic [11:0] DataIn;
    logic        InLast;
    logic        OutReady;

    logic        ir_a, ov_a, ol_a, ir_d, ov_d, ol_d;
    logic [11:0] do_a, do_d;
    logic [3:0]  cnt_a, cnt_d;

    int n_pass  = 0;
    int n_total = 0;

    logic [11:0] in_w  [12];
    logic [11:0] exp_a [12];
    logic [11:0] exp_d [12];

    typedef struct {
        logic [7:0] key;
        logic [3:0] idx;
        logic [7:0] ekey;
        logic [3:0] eidx;
    } vec_t;
    vec_t tbl [12];

    always #5 Clk = ~Clk;

    seq_sort_stream #(.KEY_W(8), .IDX_W(4), .DEPTH(12), .DESCEND(0)) u_asc (
        .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(ir_a), .DataIn(DataIn),
        .InLast(InLast), .OutValid(ov_a), .OutReady(OutReady), .DataOut(do_a),
        .OutLast(ol_a), .Count(cnt_a));

    seq_sort_stream #(.KEY_W(8), .IDX_W(4), .DEPTH(12), .DESCEND(1)) u_desc (
        .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(ir_d), .DataIn(DataIn),
        .InLast(InLast), .OutValid(ov_d), .OutReady(OutReady), .DataOut(do_d),
        .OutLast(ol_d), .Count(cnt_d));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Stable sort by repeated selection of the earliest extreme key.
    task automatic build_expect(input int n);
        bit used_a [12];
        bit used_d [12];
        for (int i = 0; i < 12; i++) begin used_a[i] = 0; used_d[i] = 0; end
        for (int k = 0; k < n; k++) begin
            int ba = -1;
            int bd = -1;
            for (int j = 0; j < n; j++) begin
                if (!used_a[j] && (ba < 0 || in_w[j][11:4] < in_w[ba][11:4])) ba = j;
                if (!used_d[j] && (bd < 0 || in_w[j][11:4] > in_w[bd][11:4])) bd = j;
            end
            used_a[ba] = 1;
            used_d[bd] = 1;
            exp_a[k] = in_w[ba];
            exp_d[k] = in_w[bd];
        end
    endtask

    task automatic push_frame(input int n, input bit lastflag, input bit stall);
        for (int i = 0; i < n; i++) begin
            int g = 0;
            if (stall) begin
                while ($urandom_range(0, 2) == 0) begin
                    InValid = 1'b0;
                    tick();
                end
            end
            InValid = 1'b1;
            DataIn  = in_w[i];
            InLast  = lastflag && (i == n - 1);
            while (!ir_a && g < 50) begin tick(); g++; end
            chk("fill_inready", {31'd0, ir_a & ir_d}, 32'd1);
            chk("fill_count_a", {28'd0, cnt_a}, i);
            chk("fill_count_d", {28'd0, cnt_d}, i);
            tick();
        end
        InValid = 1'b0;
        InLast  = 1'b0;
        if (lastflag || n == 12) begin
            chk("drain_ovalid_a", {31'd0, ov_a}, 32'd1);
            chk("drain_ovalid_d", {31'd0, ov_d}, 32'd1);
            chk("drain_inready",  {31'd0, ir_a | ir_d}, 32'd0);
            chk("drain_count",    {28'd0, cnt_a}, n);
        end
    endtask

    // mode 0: always ready, 1: ready every third cycle, 2: random ready
    task automatic drain(input int n, input int mode, input int stop);
        int k = 0, cyc = 0, guard = 0;
        while (k < stop && guard < 2000) begin
            logic rdy;
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 3) == 0) : 1'($urandom_range(0, 1));
            OutReady = rdy;
            chk("out_valid",  {31'd0, ov_a & ov_d}, 32'd1);
            chk("out_data_a", {20'd0, do_a}, {20'd0, exp_a[k]});
            chk("out_data_d", {20'd0, do_d}, {20'd0, exp_d[k]});
            chk("out_last_a", {31'd0, ol_a}, (k == n - 1) ? 32'd1 : 32'd0);
            chk("out_last_d", {31'd0, ol_d}, (k == n - 1) ? 32'd1 : 32'd0);
            chk("out_count",  {28'd0, cnt_a}, n - k);
            chk("out_count_d",{28'd0, cnt_d}, n - k);
            tick();
            if (rdy) k++;
            cyc++;
            guard++;
        end
        OutReady = 1'b0;
        chk("drain_done", k, stop);
        if (stop == n) begin
            chk("post_inready", {31'd0, ir_a & ir_d}, 32'd1);
            chk("post_ovalid",  {31'd0, ov_a | ov_d}, 32'd0);
            chk("post_count",   {28'd0, cnt_a | cnt_d}, 32'd0);
        end
    endtask

    task automatic load_table();
        for (int i = 0; i < 12; i++) begin
            in_w[i]  = {tbl[i].key, tbl[i].idx};
            exp_a[i] = {tbl[i].ekey, tbl[i].eidx};
            exp_d[i] = {tbl[11-i].ekey, tbl[11-i].eidx};
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{8'd246, 4'd0,  8'd64,  4'd1};
        tbl[1]  = '{8'd64,  4'd1,  8'd82,  4'd3};
        tbl[2]  = '{8'd234, 4'd2,  8'd104, 4'd4};
        tbl[3]  = '{8'd82,  4'd3,  8'd123, 4'd11};
        tbl[4]  = '{8'd104, 4'd4,  8'd140, 4'd10};
        tbl[5]  = '{8'd151, 4'd5,  8'd141, 4'd6};
        tbl[6]  = '{8'd141, 4'd6,  8'd142, 4'd9};
        tbl[7]  = '{8'd229, 4'd7,  8'd151, 4'd5};
        tbl[8]  = '{8'd198, 4'd8,  8'd198, 4'd8};
        tbl[9]  = '{8'd142, 4'd9,  8'd229, 4'd7};
        tbl[10] = '{8'd140, 4'd10, 8'd234, 4'd2};
        tbl[11] = '{8'd123, 4'd11, 8'd246, 4'd0};

        Reset = 1'b1; InValid = 1'b0; DataIn = '0; InLast = 1'b0; OutReady = 1'b0;
        tick(); tick();
        chk("rst_inready", {31'd0, ir_a & ir_d}, 32'd1);
        chk("rst_ovalid",  {31'd0, ov_a | ov_d}, 32'd0);
        chk("rst_data",    {20'd0, do_a | do_d}, 32'd0);
        chk("rst_last",    {31'd0, ol_a | ol_d}, 32'd0);
        chk("rst_count",   {28'd0, cnt_a | cnt_d}, 32'd0);
        Reset = 1'b0;
        tick();

        // Table frame: ascending and descending order, full-rate drain
        load_table();
        push_frame(12, 1, 0);
        drain(12, 0, 12);

        // Same frame with consumer backpressure
        load_table();
        push_frame(12, 1, 0);
        drain(12, 1, 12);

        // Equal keys keep arrival order
        in_w[0] = {8'd50, 4'd0}; in_w[1] = {8'd20, 4'd1};
        in_w[2] = {8'd50, 4'd2}; in_w[3] = {8'd20, 4'd3};
        exp_a[0] = {8'd20, 4'd1}; exp_a[1] = {8'd20, 4'd3};
        exp_a[2] = {8'd50, 4'd0}; exp_a[3] = {8'd50, 4'd2};
        exp_d[0] = {8'd50, 4'd0}; exp_d[1] = {8'd50, 4'd2};
        exp_d[2] = {8'd20, 4'd1}; exp_d[3] = {8'd20, 4'd3};
        push_frame(4, 1, 0);
        drain(4, 0, 4);

        // Full frame without InLast forces a drain; extra word is refused
        load_table();
        push_frame(12, 0, 0);
        InValid = 1'b1; DataIn = {8'd99, 4'd15}; InLast = 1'b1;
        tick(); tick();
        chk("ovf_count", {28'd0, cnt_a}, 32'd12);
        chk("ovf_head",  {20'd0, do_a}, {20'd0, 8'd64, 4'd1});
        InValid = 1'b0; InLast = 1'b0;
        drain(12, 0, 12);
        in_w[0] = {8'd7, 4'd5}; exp_a[0] = {8'd7, 4'd5}; exp_d[0] = {8'd7, 4'd5};
        push_frame(1, 1, 0);
        drain(1, 0, 1);

        // Reset in the middle of a drain discards the frame
        load_table();
        push_frame(12, 1, 0);
        drain(12, 0, 3);
        #2 Reset = 1'b1;
        #1;
        chk("mrst_ovalid",  {31'd0, ov_a | ov_d}, 32'd0);
        chk("mrst_count",   {28'd0, cnt_a | cnt_d}, 32'd0);
        chk("mrst_inready", {31'd0, ir_a & ir_d}, 32'd1);
        chk("mrst_data",    {20'd0, do_a | do_d}, 32'd0);
        #2 Reset = 1'b0;
        tick();
        in_w[0] = {8'd9, 4'd1}; in_w[1] = {8'd3, 4'd2};
        exp_a[0] = {8'd3, 4'd2}; exp_a[1] = {8'd9, 4'd1};
        exp_d[0] = {8'd9, 4'd1}; exp_d[1] = {8'd3, 4'd2};
        push_frame(2, 1, 0);
        drain(2, 0, 2);

        // Randomised frames with stalls on both sides
        for (int f = 0; f < 30; f++) begin
            int  len;
            bit  lf;
            bit  narrow;
            len    = $urandom_range(1, 12);
            lf     = (len < 12) ? 1'b1 : 1'($urandom_range(0, 1));
            narrow = 1'($urandom_range(0, 1));
            for (int i = 0; i < len; i++) begin
                in_w[i][11:4] = narrow ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
                in_w[i][3:0]  = 4'(i);
            end
            build_expect(len);
            push_frame(len, lf, 1);
            drain(len, 2, len);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
